f3m_serial_mult_ctrl: RTL

- Sequencer for a digit-serial GF(3^M) multiplier built from GF(3) multiply/add cells.
- Computes C = A*B mod p(x), with p(x) = x^M + x^K + 2, MSB-first: one coefficient of A per cycle, M cycles total.
- Sits between the pairing/Miller-loop controller and the field datapath.
- Owns the start/busy/done handshake and the operand/result registers.

---
 rtl/f3m_serial_mult_ctrl_pkg.sv | 34 +++
 rtl/f3m_mult_step.sv | 40 ++++
 rtl/f3m_serial_mult_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/f3m_serial_mult_ctrl_pkg.sv
// Shared GF(3) definitions for the digit-serial GF(3^M) multiplier:
// coefficient codes, FSM encoding, default field parameters and cell functions.
package f3m_serial_mult_ctrl_pkg;

    localparam logic [1:0] F3_ZERO = 2'b00;
    localparam logic [1:0] F3_ONE  = 2'b01;
    localparam logic [1:0] F3_TWO  = 2'b10;

    localparam int M_DEF = 97;
    localparam int K_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The unused code 2'b11 behaves as zero everywhere in the datapath.
    function automatic logic [1:0] f3_norm(input logic [1:0] a);
        return (a == 2'b11) ? F3_ZERO : a;
    endfunction

    function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [1:0] f3_mul(input logic [1:0] a, input logic [1:0] b);
        if (a == F3_ZERO || b == F3_ZERO) return F3_ZERO;
        return (a == b) ? F3_ONE : F3_TWO;
    endfunction

endpackage

// File: rtl/f3m_mult_step.sv
// One MSB-first iteration: acc_nxt = reduce(acc*x) + a_digit*B over GF(3^M),
// with p(x) = x^M + x^K + 2, so the shifted-out coefficient folds into x^0 and 2x^K.
module f3m_mult_step
    import f3m_serial_mult_ctrl_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int K = K_DEF
) (
    input  logic [2*M-1:0] i_acc,
    input  logic [1:0]     i_a_digit,
    input  logic [2*M-1:0] i_b,
    output logic [2*M-1:0] o_acc_nxt
);

    logic [1:0] w_top;
    logic [1:0] w_a;

    assign w_top = i_acc[2*M-1 -: 2];
    assign w_a   = f3_norm(i_a_digit);

    for (genvar i = 0; i < M; i++) begin : g_coef
        logic [1:0] w_prev;
        logic [1:0] w_fb;

        if (i == 0) begin : g_lo
            assign w_prev = F3_ZERO;
            assign w_fb   = w_top;
        end else if (i == K) begin : g_tap
            assign w_prev = i_acc[2*i-1 -: 2];
            assign w_fb   = f3_mul(F3_TWO, w_top);
        end else begin : g_mid
            assign w_prev = i_acc[2*i-1 -: 2];
            assign w_fb   = F3_ZERO;
        end

        assign o_acc_nxt[2*i +: 2] = f3_add(f3_add(w_prev, w_fb),
                                            f3_mul(w_a, f3_norm(i_b[2*i +: 2])));
    end

endmodule

// File: rtl/f3m_serial_mult_ctrl.sv
// Sequencer for the digit-serial GF(3^M) multiplier: start/busy/done handshake,
// operand/result registers. Optional operand check enabled by F3_OPERAND_CHECK_EN.
module f3m_serial_mult_ctrl
    import f3m_serial_mult_ctrl_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int K = K_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*M-1:0] A,
    input  logic [2*M-1:0] B,
    output logic           busy,
    output logic           done,
`ifdef F3_OPERAND_CHECK_EN
    output logic           err,
`endif
    output logic [2*M-1:0] C
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    state_t         r_state, w_nxt;
    logic [CW-1:0]  r_cnt;
    logic [2*M-1:0] r_a, r_b, r_acc, r_c;
    logic [2*M-1:0] w_step;
    logic [1:0]     w_adig;
    logic           w_abort;

    assign w_adig = r_a[{r_cnt, 1'b0} +: 2];

    f3m_mult_step #(.M(M), .K(K)) u_step (
        .i_acc     (r_acc),
        .i_a_digit (w_adig),
        .i_b       (r_b),
        .o_acc_nxt (w_step)
    );

`ifdef F3_OPERAND_CHECK_EN
    logic r_err, w_bad;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < M; i++)
            if (A[2*i +: 2] == 2'b11 || B[2*i +: 2] == 2'b11) w_bad = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_err <= 1'b0;
        else if (r_state == ST_IDLE && start) r_err <= w_bad;
    end

    assign w_abort = r_err;
    assign err     = r_err;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == '0 || w_abort) w_nxt = ST_DONE;
            ST_DONE: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_c     <= '0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a   <= A;
                    r_b   <= B;
                    r_acc <= '0;
                    r_cnt <= CW'(M - 1);
                end
                ST_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                    // A rejected operand still finishes through DONE, but with a zero product.
                    if (w_abort)           r_c <= '0;
                    else if (r_cnt == '0)  r_c <= w_step;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign C    = r_c;

endmodule
